// File: rtl/piradip_spi_bit_engine.sv
// SPI bit-serial engine: one transfer per command, MOSI/MISO exchanged as single-bit
// valid/ready streams, with programmable SCLK half-period and CPOL/CPHA mode.
module piradip_spi_bit_engine #(
    parameter int DIV_WIDTH = 8,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cfg_cpol,
    input  logic                 cfg_cpha,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic                 tx_bit_valid,
    input  logic                 tx_bit_data,
    output logic                 tx_bit_ready,
    output logic                 rx_bit_valid,
    output logic                 rx_bit_data,
    input  logic                 rx_bit_ready,
    output logic                 align,
    output logic                 done,
    output logic                 busy,
    output logic                 sclk,
    output logic                 mosi,
    output logic                 csn,
    input  logic                 miso
);

    // state | meaning: IDLE accept cmd | SETUP csn lead | WAIT next tx bit |
    // PHASE_A/B sclk half-periods | HOLD csn lag | DONE end pulse
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WAIT,
        ST_PHASE_A,
        ST_PHASE_B,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = '0;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO = '0;
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);

    state_t               state;
    logic                 cpol_q;
    logic                 cpha_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [LEN_WIDTH-1:0] bits_left;
    logic                 div_tc;
    logic                 tx_fire;
    logic                 rx_fire;

    // Ready is held low for the whole reset so nothing is accepted before release.
    assign cmd_ready    = (state == ST_IDLE) && rstn;
    assign busy         = (state != ST_IDLE);
    assign tx_bit_ready = (state == ST_WAIT) && (!rx_bit_valid || rx_bit_ready);
    assign tx_fire      = tx_bit_valid && tx_bit_ready;
    assign rx_fire      = rx_bit_valid && rx_bit_ready;
    assign div_tc       = (div_cnt == DIV_ZERO);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
            div_q        <= DIV_ZERO;
            div_cnt      <= DIV_ZERO;
            bits_left    <= LEN_ZERO;
            sclk         <= 1'b0;
            mosi         <= 1'b0;
            csn          <= 1'b1;
            rx_bit_valid <= 1'b0;
            rx_bit_data  <= 1'b0;
            align        <= 1'b0;
            done         <= 1'b0;
        end else begin
            align <= 1'b0;
            done  <= 1'b0;
            if (rx_fire) begin
                rx_bit_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    sclk <= cfg_cpol;
                    mosi <= 1'b0;
                    csn  <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cpol_q    <= cfg_cpol;
                        cpha_q    <= cfg_cpha;
                        div_q     <= cfg_div;
                        div_cnt   <= cfg_div;
                        bits_left <= cmd_len;
                        if (cmd_len == LEN_ZERO) begin
                            state <= ST_DONE;
                            align <= 1'b1;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_SETUP;
                            csn   <= 1'b0;
                        end
                    end
                end

                ST_SETUP: begin
                    if (div_tc) begin
                        state <= ST_WAIT;
                    end else begin
                        div_cnt <= div_cnt - DIV_ONE;
                    end
                end

                ST_WAIT: begin
                    if (tx_fire) begin
                        mosi    <= tx_bit_data;
                        sclk    <= cpol_q ^ cpha_q;
                        div_cnt <= div_q;
                        state   <= ST_PHASE_A;
                    end
                end

                ST_PHASE_A: begin
                    if (div_tc) begin
                        rx_bit_data  <= miso;
                        rx_bit_valid <= 1'b1;
                        sclk         <= ~(cpol_q ^ cpha_q);
                        div_cnt      <= div_q;
                        state        <= ST_PHASE_B;
                    end else begin
                        div_cnt <= div_cnt - DIV_ONE;
                    end
                end

                ST_PHASE_B: begin
                    if (div_tc) begin
                        sclk      <= cpol_q;
                        div_cnt   <= div_q;
                        bits_left <= bits_left - LEN_ONE;
                        state     <= (bits_left == LEN_ONE) ? ST_HOLD : ST_WAIT;
                    end else begin
                        div_cnt <= div_cnt - DIV_ONE;
                    end
                end

                ST_HOLD: begin
                    if (div_tc) begin
                        csn   <= 1'b1;
                        align <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        div_cnt <= div_cnt - DIV_ONE;
                    end
                end

                ST_DONE: begin
                    sclk  <= cfg_cpol;
                    mosi  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piradip_spi_bit_engine.sv
// Directed bench for piradip_spi_bit_engine: expected MISO bits are queued at stimulus
// time and a negedge monitor pops and compares them on every rx handshake.
module tb_piradip_spi_bit_engine;

    localparam int DW = 8;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          cfg_cpol = 1'b0;
    logic          cfg_cpha = 1'b0;
    logic [DW-1:0] cfg_div = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len = '0;
    logic          tx_bit_valid = 1'b0;
    logic          tx_bit_data = 1'b0;
    logic          tx_bit_ready;
    logic          rx_bit_valid;
    logic          rx_bit_data;
    logic          rx_bit_ready = 1'b1;
    logic          align;
    logic          done;
    logic          busy;
    logic          sclk;
    logic          mosi;
    logic          csn;
    logic          miso;

    logic loop_en = 1'b1;
    logic miso_flip = 1'b0;
    logic miso_pat = 1'b0;
    assign miso = loop_en ? (mosi ^ miso_flip) : miso_pat;

    bit exp_q[$];
    bit tx_q[$];

    int n_vec = 0;
    int n_miss = 0;
    int n_rx = 0;
    int n_tx = 0;
    int n_rise = 0;
    int n_csn_low = 0;
    int n_done = 0;
    int n_align = 0;
    int lo_min = 1000;
    int lo_max = 0;
    int low_run = 0;
    int tx_gap = 0;
    int gap_after = -1;
    int gap_len = 0;
    logic prev_sclk = 1'b0;

    piradip_spi_bit_engine #(.DIV_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .cfg_cpol     (cfg_cpol),
        .cfg_cpha     (cfg_cpha),
        .cfg_div      (cfg_div),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_len      (cmd_len),
        .tx_bit_valid (tx_bit_valid),
        .tx_bit_data  (tx_bit_data),
        .tx_bit_ready (tx_bit_ready),
        .rx_bit_valid (rx_bit_valid),
        .rx_bit_data  (rx_bit_data),
        .rx_bit_ready (rx_bit_ready),
        .align        (align),
        .done         (done),
        .busy         (busy),
        .sclk         (sclk),
        .mosi         (mosi),
        .csn          (csn),
        .miso         (miso)
    );

    initial forever #5 clk = ~clk;

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_counts();
        n_rx = 0;
        n_tx = 0;
        n_rise = 0;
        n_csn_low = 0;
        n_done = 0;
        n_align = 0;
        lo_min = 1000;
        lo_max = 0;
    endtask

    // Bits go out MSB-first from pat[len-1]; rx expectation is the loopback copy or all ones.
    task automatic load_bits(input logic [15:0] pat, input int len, input bit rx_from_tx);
        for (int i = len - 1; i >= 0; i--) begin
            tx_q.push_back(pat[i]);
            exp_q.push_back(rx_from_tx ? pat[i] : 1'b1);
        end
    endtask

    task automatic issue_cmd(input logic cpol, input logic cpha, input int div, input int len);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        cfg_cpol  = cpol;
        cfg_cpha  = cpha;
        cfg_div   = DW'(div);
        cmd_len   = LW'(len);
        cmd_valid = 1'b1;
        #1;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        check("cmd_ready_seen", seen, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cfg_cpha  = ~cpha;
        cfg_div   = DW'(div + 3);
        cmd_len   = LW'(len + 5);
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #3;
            if (n_done > 0) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_within_budget", seen, 1'b1);
        repeat (3) @(negedge clk);
        #3;
    endtask

    task automatic check_xfer(input int rises, input int csn_low);
        check("done_pulses", n_done, 1);
        check("align_pulses", n_align, 1);
        check("sclk_rises", n_rise, rises);
        check("csn_low_cycles", n_csn_low, csn_low);
        check("rx_left_in_queue", exp_q.size(), 0);
    endtask

    initial begin : tx_driver
        bit discard;
        forever begin
            @(negedge clk);
            if (tx_gap > 0) begin
                tx_bit_valid = 1'b0;
                tx_gap--;
            end else if (tx_q.size() > 0) begin
                tx_bit_valid = 1'b1;
                tx_bit_data  = tx_q[0];
            end else begin
                tx_bit_valid = 1'b0;
            end
            #1;
            if (tx_bit_valid && tx_bit_ready) begin
                discard = tx_q.pop_front();
                n_tx++;
                if (n_tx == gap_after) tx_gap = gap_len;
            end
        end
    end

    initial begin : monitor
        bit expv;
        forever begin
            @(negedge clk);
            #2;
            if (!csn) n_csn_low++;
            if (done) n_done++;
            if (align) n_align++;
            if (!csn && !prev_sclk && sclk) begin
                n_rise++;
                if (low_run < lo_min) lo_min = low_run;
                if (low_run > lo_max) lo_max = low_run;
            end
            low_run   = sclk ? 0 : low_run + 1;
            miso_pat  = (low_run == 3);
            prev_sclk = sclk;
            if (rx_bit_valid && rx_bit_ready) begin
                n_rx++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL rx_extra: got bit %0d with nothing expected (t=%0t)", rx_bit_data, $time);
                end else begin
                    expv = exp_q.pop_front();
                    check("rx_bit", rx_bit_data, expv);
                end
            end
        end
    end

    initial begin : stimulus
        #1 rstn = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check("rst_csn", csn, 1'b1);
        check("rst_sclk", sclk, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_align", align, 1'b0);
        check("rst_rx_valid", rx_bit_valid, 1'b0);
        check("rst_rx_data", rx_bit_data, 1'b0);
        check("rst_tx_ready", tx_bit_ready, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("post_rst_cmd_ready", cmd_ready, 1'b1);
        check("post_rst_busy", busy, 1'b0);

        // Mode 0, div 0, 8 bits loopback.
        clear_counts();
        load_bits(16'b1010_0101, 8, 1'b1);
        issue_cmd(1'b0, 1'b0, 0, 8);
        wait_done(200);
        check_xfer(8, 26);

        // tx source stalls for 5 cycles after bit 3: 3 extra WAIT cycles.
        clear_counts();
        gap_after = 3;
        gap_len   = 5;
        load_bits(16'b0000_0000_0011_0010, 6, 1'b1);
        issue_cmd(1'b0, 1'b0, 0, 6);
        wait_done(200);
        check_xfer(6, 23);
        gap_after = -1;

        // rx backpressure after bit 1 is consumed: bit 2 stays pending, bit 3 waits.
        clear_counts();
        load_bits(16'b0000_0000_0000_0110, 4, 1'b1);
        issue_cmd(1'b0, 1'b0, 0, 4);
        begin : wait_rx1
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (n_rx >= 1) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("rx1_seen", seen, 1'b1);
        end
        rx_bit_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            miso_flip = ~miso_flip;
            #2;
            check("stall_tx_ready", tx_bit_ready, 1'b0);
            check("stall_rx_valid", rx_bit_valid, 1'b1);
            check("stall_rx_data", rx_bit_data, 1'b1);
        end
        check("stall_rises", n_rise, 2);
        @(negedge clk);
        miso_flip    = 1'b0;
        rx_bit_ready = 1'b1;
        wait_done(200);
        check_xfer(4, 18);

        // Mode 3, div 2: miso is high only in the last low cycle of each half-period.
        @(negedge clk);
        cfg_cpol = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check("idle_sclk_cpol1", sclk, 1'b1);
        loop_en = 1'b0;
        clear_counts();
        load_bits(16'b0000_0000_0000_1100, 4, 1'b0);
        issue_cmd(1'b1, 1'b1, 2, 4);
        wait_done(400);
        check_xfer(4, 34);
        check("low_half_min", lo_min, 3);
        check("low_half_max", lo_max, 3);
        loop_en = 1'b1;

        // Zero-length command.
        clear_counts();
        issue_cmd(1'b0, 1'b0, 0, 0);
        #2;
        check("len0_done", done, 1'b1);
        check("len0_align", align, 1'b1);
        check("len0_csn", csn, 1'b1);
        check("len0_busy", busy, 1'b1);
        check("len0_cmd_ready", cmd_ready, 1'b0);
        @(negedge clk);
        #2;
        check("len0_done_cleared", done, 1'b0);
        check("len0_idle_ready", cmd_ready, 1'b1);
        repeat (2) @(negedge clk);
        #3;
        check("len0_done_pulses", n_done, 1);
        check("len0_align_pulses", n_align, 1);
        check("len0_csn_low", n_csn_low, 0);
        check("len0_rises", n_rise, 0);

        // Mode 2, div 3: reset in the first PHASE_A cycle of bit 5.
        clear_counts();
        load_bits(16'b1101_1010, 8, 1'b1);
        issue_cmd(1'b1, 1'b0, 3, 8);
        begin : wait_bit5
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                #3;
                if (n_tx >= 5) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("bit5_started", seen, 1'b1);
        end
        @(negedge clk);
        #2;
        check("pre_rst_csn", csn, 1'b0);
        check("pre_rst_sclk", sclk, 1'b1);
        check("pre_rst_mosi", mosi, 1'b1);
        rstn = 1'b0;
        #1;
        check("abort_csn", csn, 1'b1);
        check("abort_sclk", sclk, 1'b0);
        check("abort_mosi", mosi, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_cmd_ready", cmd_ready, 1'b0);
        check("abort_tx_ready", tx_bit_ready, 1'b0);
        repeat (3) @(negedge clk);
        tx_q.delete();
        exp_q.delete();
        check("abort_done_pulses", n_done, 0);
        check("abort_align_pulses", n_align, 0);
        check("abort_rx_count", n_rx, 4);
        rstn = 1'b1;
        #1;
        check("release_cmd_ready", cmd_ready, 1'b1);
        check("release_busy", busy, 1'b0);

        clear_counts();
        load_bits(16'b0000_0000_0000_0101, 3, 1'b1);
        issue_cmd(1'b0, 1'b0, 0, 3);
        wait_done(200);
        check_xfer(3, 11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
